vector_cmd_parser: RTL and testbench
====================================

# vector_cmd_parser

Byte-stream command parser and buffer upstream of the `control` line-drawing block. Consumes bytes from the UART receiver and assembles 5-byte packets into draw/jump commands. Buffers them in a FIFO and issues them to `control` through its `x`/`y`/`shift`/`draw`/`jump`/`ready` handshake. Replaces the hard-coded pattern generator so a host can stream vector lists.

## Interface
- `DEPTH`, 16: command FIFO depth in entries; power of 2, at least 2.
- `TIMEOUT`, 50000: maximum idle cycles between bytes of one packet before the partial packet is discarded.
- `clk` input 1: system clock; all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `rx_data` input 8: received byte; valid only while `rx_valid` is high.
- `rx_valid` input 1: one-cycle strobe, one byte per strobe.
- `ready` input 1: `control` can accept a command.
- `x` output 12: target X for `control`.
- `y` output 12: target Y for `control`.
- `shift` output 4: speed/shift value for `control`.
- `draw` output 1: one-cycle pulse that issues a draw command.
- `jump` output 1: one-cycle pulse that issues a jump command.
- `overflow` output 1: sticky flag; a command was dropped because the FIFO was full.
- `fifo_level` output $clog2(DEPTH)+1: current number of FIFO entries.

## Operation
- **Header byte** (bit7=1):
  - bits[6:5] = opcode: 00 NOP, 01 DRAW, 10 JUMP, 11 FLUSH.
  - bit4 is reserved and ignored.
  - bits[3:0] = shift.
- **Data bytes** (bit7=0): bit6 is ignored; bits[5:0] carry the payload.
- **Packet** = header followed by D1=x[11:6], D2=x[5:0], D3=y[11:6], D4=y[5:0].
- **Assembler states:**
  - IDLE → D1 on any header except FLUSH.
  - D1 → D2 → D3 → D4, advancing on each data byte.
  - After D4, return to IDLE.
  - A data byte received in IDLE is discarded.
  - A header byte received in D1..D4 discards the partial packet and starts a new one: state goes to D1, or to the FLUSH action if the new header is FLUSH.
- **Timeout:** an idle counter resets on every `rx_valid`. When it reaches `TIMEOUT` in a D1..D4 state, the partial packet is discarded and the state returns to IDLE.
- **FLUSH** executes on the header byte itself:
  - empties the FIFO and clears `overflow`;
  - state stays in IDLE;
  - a pop in the same cycle is cancelled; an issue pulse already registered completes.
- **NOP:** the packet is consumed in full and nothing is pushed.
- **Push:** on the edge that samples the D4 byte of a DRAW or JUMP packet, the entry {op, x, y, shift} is written.
  - If the FIFO is full and no pop occurs in that cycle, the entry is dropped and `overflow` is set.
  - A simultaneous pop frees a slot, so the push is accepted.
- **Issue:** at a rising edge where the FIFO is non-empty, `ready` is 1, and both `draw` and `jump` are 0:
  - pop the head entry;
  - register `x`, `y`, `shift`;
  - set `draw` or `jump` (per op) for exactly one cycle.
- **Issue spacing:** pulses are never back-to-back; at least one low cycle separates them, which gives `control` a cycle to drop `ready`.
- **Output hold:** `x`, `y`, `shift` hold their values until the next issue.
- **Pointers:** read/write pointers wrap modulo `DEPTH`; the level counter saturates at neither end because push is blocked when full and pop when empty.

## Timing
- **Reset values:** `x`=0, `y`=0, `shift`=0, `draw`=0, `jump`=0, `overflow`=0, `fifo_level`=0; assembler in IDLE; timeout counter 0.
- **Reset mid-packet or mid-issue** aborts everything immediately, asynchronously.
- **Latency:** with the FIFO empty and `ready`=1, `draw`/`jump` rises at the first edge after the edge that sampled D4.
  - That is 1 cycle of FIFO latency, and `fifo_level` reads 1 for that cycle.
- **Throughput:** at most one issue every 2 cycles. Input is at most one byte per cycle.
- **`ready` deasserted:** when `ready` is 0, entries wait with no timeout and the outputs hold.
- **Same-cycle push and pop:** `fifo_level` is unchanged.

## Test plan
- **Single draw:** bytes A3 01 24 00 0A with `ready`=1 → one `draw` pulse, `x`=100, `y`=10, `shift`=3, `jump` stays 0; pulse occurs 1 cycle after the D4 edge.
- **Single jump:** bytes C0 3F 3F 3F 3F → one `jump` pulse, `x`=4095, `y`=4095, `shift`=0.
- **Backpressure and overflow:** `ready`=0, send DEPTH+1 draw packets → `fifo_level`=DEPTH, `overflow`=1. Then raise `ready` → exactly DEPTH pulses, in order, each separated by at least one low cycle. Then send E0 → `overflow`=0.
- **Resync:** bytes A3 01 24 followed by C0 00 01 00 02 → only a jump to (1,2); the stray data byte 05 sent in IDLE produces no push.
- **Timeout:** send A3 01, wait TIMEOUT+1 cycles, send 24 00 0A → nothing issued, `fifo_level`=0.
- **Reset and flush mid-operation:** assert `reset_n`=0 while 3 entries are queued and `draw` is high → all outputs 0 immediately. In a separate run, send E0 while 3 entries are queued and `ready`=0 → `fifo_level`=0 on the next cycle, and no pulse when `ready` returns.

Source files
------------

// File: rtl/vector_cmd_parser.sv
// vector_cmd_parser
// Assembles 5-byte host packets (header + four 6-bit data bytes) from a UART
// byte stream into draw/jump commands. Commands are queued in a small FIFO
// and issued to the line-drawing controller through a ready/pulse handshake.
//
// Ports
//   clk, reset_n         system clock, async active-low reset
//   rx_data, rx_valid    received byte and its one-cycle strobe
//   ready                controller can accept a command
//   x, y, shift          registered command fields, held until next issue
//   draw, jump           one-cycle issue pulses, never back-to-back
//   overflow             sticky: a command was dropped on a full FIFO
//   fifo_level           current FIFO occupancy
//
// Assembler states
//   state  | meaning
//   S_IDLE | waiting for a header; data bytes are discarded
//   S_D1   | header seen, expecting x[11:6]
//   S_D2   | expecting x[5:0]
//   S_D3   | expecting y[11:6]
//   S_D4   | expecting y[5:0]; push on DRAW/JUMP
module vector_cmd_parser #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   input  logic                   ready,
   output logic [11:0]            x,
   output logic [11:0]            y,
   output logic [3:0]             shift,
   output logic                   draw,
   output logic                   jump,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] fifo_level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] OP_DRAW  = 2'b01;
   localparam logic [1:0] OP_JUMP  = 2'b10;
   localparam logic [1:0] OP_FLUSH = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_D1, S_D2, S_D3, S_D4} asm_state_t;

   typedef struct packed {
      logic        is_jump;
      logic [11:0] x;
      logic [11:0] y;
      logic [3:0]  shift;
   } cmd_t;

   asm_state_t    state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic [3:0]    shift_acc_q, shift_acc_d;
   logic [11:0]   x_acc_q, x_acc_d;
   logic [5:0]    y_hi_q, y_hi_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          ovf_q, ovf_d;
   logic [11:0]   x_q, x_d;
   logic [11:0]   y_q, y_d;
   logic [3:0]    shift_q, shift_d;
   logic          draw_q, draw_d;
   logic          jump_q, jump_d;

   cmd_t mem_q [DEPTH];

   logic hdr, dat, flush, push_req, push_ok, pop;
   cmd_t push_cmd, head;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      shift_acc_d = shift_acc_q;
      x_acc_d     = x_acc_q;
      y_hi_d      = y_hi_q;
      tmr_d       = tmr_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      ovf_d       = ovf_q;
      x_d         = x_q;
      y_d         = y_q;
      shift_d     = shift_q;
      draw_d      = 1'b0;
      jump_d      = 1'b0;
      push_req    = 1'b0;

      hdr   = rx_valid & rx_data[7];
      dat   = rx_valid & ~rx_data[7];
      flush = hdr && (rx_data[6:5] == OP_FLUSH);

      push_cmd = {(op_q == OP_JUMP), x_acc_q, y_hi_q, rx_data[5:0], shift_acc_q};
      head     = mem_q[rd_ptr_q];

      // Inter-byte timer: reloaded on every byte, expires at zero.
      if (rx_valid) begin
         tmr_d = TW'(TIMEOUT);
      end else if (tmr_q != '0) begin
         tmr_d = tmr_q - TW'(1);
      end

      if (hdr) begin
         // A header always restarts assembly, discarding any partial packet.
         state_d = flush ? S_IDLE : S_D1;
         if (!flush) begin
            op_d        = rx_data[6:5];
            shift_acc_d = rx_data[3:0];
         end
      end else if (dat) begin
         case (state_q)
            S_D1: begin
               x_acc_d[11:6] = rx_data[5:0];
               state_d       = S_D2;
            end
            S_D2: begin
               x_acc_d[5:0] = rx_data[5:0];
               state_d      = S_D3;
            end
            S_D3: begin
               y_hi_d  = rx_data[5:0];
               state_d = S_D4;
            end
            S_D4: begin
               state_d  = S_IDLE;
               push_req = (op_q == OP_DRAW) || (op_q == OP_JUMP);
            end
            default: ;
         endcase
      end else if ((state_q != S_IDLE) && (tmr_q == '0)) begin
         state_d = S_IDLE;
      end

      // Issue only when no pulse is currently out, guaranteeing a low cycle
      // between pulses; a flush in the same cycle wins over the pop.
      pop     = (level_q != '0) && ready && !draw_q && !jump_q && !flush;
      push_ok = push_req && ((level_q != LW'(DEPTH)) || pop);

      if (pop) begin
         x_d      = head.x;
         y_d      = head.y;
         shift_d  = head.shift;
         draw_d   = !head.is_jump;
         jump_d   = head.is_jump;
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (push_req && !push_ok) begin
         ovf_d = 1'b1;
      end
      level_d = level_q + LW'(push_ok) - LW'(pop);

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         ovf_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         shift_acc_q <= '0;
         x_acc_q     <= '0;
         y_hi_q      <= '0;
         tmr_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         ovf_q       <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         shift_q     <= '0;
         draw_q      <= 1'b0;
         jump_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         shift_acc_q <= shift_acc_d;
         x_acc_q     <= x_acc_d;
         y_hi_q      <= y_hi_d;
         tmr_q       <= tmr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         ovf_q       <= ovf_d;
         x_q         <= x_d;
         y_q         <= y_d;
         shift_q     <= shift_d;
         draw_q      <= draw_d;
         jump_q      <= jump_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and level.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_cmd;
      end
   end

   assign x          = x_q;
   assign y          = y_q;
   assign shift      = shift_q;
   assign draw       = draw_q;
   assign jump       = jump_q;
   assign overflow   = ovf_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_vector_cmd_parser.sv
module tb_vector_cmd_parser;
   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 40;
   localparam int LW      = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic        is_jump;
      logic [11:0] x;
      logic [11:0] y;
      logic [3:0]  s;
   } cmd_t;

   typedef struct packed {
      logic [39:0] bytes;
      logic        d;
      logic        j;
      logic [11:0] x;
      logic [11:0] y;
      logic [3:0]  s;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic          ready = 1'b0;
   logic [11:0]   x, y;
   logic [3:0]    shift;
   logic          draw, jump, overflow;
   logic [LW-1:0] fifo_level;

   int   checks = 0;
   int   errors = 0;
   cmd_t obs[$];
   logic prev_pulse = 1'b0;

   always #5 clk = ~clk;

   vector_cmd_parser #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .ready(ready), .x(x), .y(y), .shift(shift), .draw(draw), .jump(jump),
      .overflow(overflow), .fifo_level(fifo_level)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [39:0] p);
      for (int k = 0; k < 5; k++) send_byte(p[39-8*k -: 8]);
   endtask

   function automatic logic [39:0] mk_pkt(input logic [1:0] op, input logic [11:0] xv,
                                          input logic [11:0] yv, input logic [3:0] s);
      return {1'b1, op, 1'b0, s, 2'b00, xv[11:6], 2'b00, xv[5:0],
              2'b00, yv[11:6], 2'b00, yv[5:0]};
   endfunction

   // Pulse monitor: records every issued command, checks exclusivity/spacing.
   always @(posedge clk) begin
      #1;
      if (reset_n) begin
         if (draw || jump) begin
            chk("pulse_exclusive", {31'b0, draw & jump}, 32'd0);
            chk("pulse_spacing", {31'b0, prev_pulse}, 32'd0);
            obs.push_back({jump, x, y, shift});
         end
         prev_pulse = draw | jump;
      end else begin
         prev_pulse = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t   tbl[5];
      cmd_t   got;
      cmd_t   exp_q[$];
      logic [7:0] pkt_q[$];
      logic [39:0] p;
      int     n;

      tbl[0] = {40'hA3_01_24_00_0A, 1'b1, 1'b0, 12'd100,  12'd10,   4'd3};
      tbl[1] = {40'hC0_3F_3F_3F_3F, 1'b0, 1'b1, 12'd4095, 12'd4095, 4'd0};
      tbl[2] = {40'h8F_01_02_03_04, 1'b0, 1'b0, 12'd4095, 12'd4095, 4'd0};
      tbl[3] = {40'hB5_7F_40_00_41, 1'b1, 1'b0, 12'd4032, 12'd1,    4'd5};
      tbl[4] = {40'hD9_12_34_05_06, 1'b0, 1'b1, 12'd1204, 12'd326,  4'd9};

      // Reset values
      idle(3);
      chk("rst_x", {20'b0, x}, 32'd0);
      chk("rst_y", {20'b0, y}, 32'd0);
      chk("rst_shift", {28'b0, shift}, 32'd0);
      chk("rst_draw", {31'b0, draw}, 32'd0);
      chk("rst_jump", {31'b0, jump}, 32'd0);
      chk("rst_overflow", {31'b0, overflow}, 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      reset_n = 1'b1;
      ready   = 1'b1;
      idle(2);

      // Table-driven single packets with latency and hold checks
      for (int i = 0; i < 5; i++) begin
         obs.delete();
         send_pkt(tbl[i].bytes);
         chk("tbl_level_at_d4", 32'(fifo_level), {31'b0, tbl[i].d | tbl[i].j});
         idle(1);
         chk("tbl_draw", {31'b0, draw}, {31'b0, tbl[i].d});
         chk("tbl_jump", {31'b0, jump}, {31'b0, tbl[i].j});
         chk("tbl_x", {20'b0, x}, {20'b0, tbl[i].x});
         chk("tbl_y", {20'b0, y}, {20'b0, tbl[i].y});
         chk("tbl_shift", {28'b0, shift}, {28'b0, tbl[i].s});
         idle(1);
         chk("tbl_pulse_one_cycle", {31'b0, draw | jump}, 32'd0);
         chk("tbl_x_hold", {20'b0, x}, {20'b0, tbl[i].x});
         idle(2);
      end

      // Resync: header mid-packet restarts; stray data byte in IDLE ignored
      obs.delete();
      send_byte(8'hA3); send_byte(8'h01); send_byte(8'h24);
      send_pkt(40'hC0_00_01_00_02);
      send_byte(8'h05);
      idle(4);
      chk("resync_count", obs.size(), 32'd1);
      got = (obs.size() > 0) ? obs[0] : '0;
      chk("resync_cmd", 32'(got), 32'({1'b1, 12'd1, 12'd2, 4'd0}));
      chk("resync_level", 32'(fifo_level), 32'd0);

      // Timeout: long gap discards partial packet, short gap does not
      obs.delete();
      send_byte(8'hA3); send_byte(8'h01);
      idle(TIMEOUT + 3);
      send_byte(8'h24); send_byte(8'h00); send_byte(8'h0A);
      idle(4);
      chk("timeout_count", obs.size(), 32'd0);
      chk("timeout_level", 32'(fifo_level), 32'd0);
      obs.delete();
      send_byte(8'hA3); send_byte(8'h01);
      idle(TIMEOUT - 3);
      send_byte(8'h24); send_byte(8'h00); send_byte(8'h0A);
      idle(3);
      chk("short_gap_count", obs.size(), 32'd1);
      got = (obs.size() > 0) ? obs[0] : '0;
      chk("short_gap_cmd", 32'(got), 32'({1'b0, 12'd100, 12'd10, 4'd3}));

      // Backpressure and overflow
      ready = 1'b0;
      for (int i = 0; i <= DEPTH; i++)
         send_pkt(mk_pkt(2'b01, 12'(i * 37 + 5), 12'(4000 - i * 3), 4'(i)));
      idle(1);
      chk("bp_level_full", 32'(fifo_level), DEPTH);
      chk("bp_overflow", {31'b0, overflow}, 32'd1);
      obs.delete();
      ready = 1'b1;
      idle(DEPTH * 2 + 6);
      chk("bp_drain_count", obs.size(), DEPTH);
      for (int i = 0; i < DEPTH && i < obs.size(); i++)
         chk("bp_drain_order", 32'(obs[i]),
             32'({1'b0, 12'(i * 37 + 5), 12'(4000 - i * 3), 4'(i)}));
      chk("bp_level_empty", 32'(fifo_level), 32'd0);
      chk("bp_overflow_sticky", {31'b0, overflow}, 32'd1);
      send_byte(8'hE0);
      chk("flush_clears_overflow", {31'b0, overflow}, 32'd0);

      // Push into a full FIFO on the same edge as a pop is accepted
      ready = 1'b0;
      obs.delete();
      for (int i = 0; i < DEPTH; i++)
         send_pkt(mk_pkt(2'b01, 12'(i + 20), 12'(i + 50), 4'(i)));
      p = mk_pkt(2'b10, 12'd777, 12'd888, 4'd12);
      for (int k = 0; k < 4; k++) send_byte(p[39-8*k -: 8]);
      rx_data  = p[7:0];
      rx_valid = 1'b1;
      ready    = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      chk("simul_level", 32'(fifo_level), DEPTH);
      chk("simul_overflow", {31'b0, overflow}, 32'd0);
      chk("simul_draw", {31'b0, draw}, 32'd1);
      idle(DEPTH * 2 + 6);
      chk("simul_count", obs.size(), DEPTH + 1);
      got = (obs.size() > DEPTH) ? obs[DEPTH] : '0;
      chk("simul_last", 32'(got), 32'({1'b1, 12'd777, 12'd888, 4'd12}));

      // Reset mid-issue
      ready = 1'b0;
      for (int i = 0; i < 3; i++) send_pkt(mk_pkt(2'b01, 12'(i + 1), 12'(i + 2), 4'd1));
      ready = 1'b1;
      n = 0;
      while (!draw && n < 10) begin
         idle(1);
         n++;
      end
      chk("rst_mid_draw_seen", {31'b0, draw}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_x", {20'b0, x}, 32'd0);
      chk("rst_mid_y", {20'b0, y}, 32'd0);
      chk("rst_mid_shift", {28'b0, shift}, 32'd0);
      chk("rst_mid_draw", {31'b0, draw}, 32'd0);
      chk("rst_mid_level", 32'(fifo_level), 32'd0);
      obs.delete();
      idle(2);
      reset_n = 1'b1;
      idle(6);
      chk("rst_mid_no_issue", obs.size(), 32'd0);

      // Flush with queued entries
      ready = 1'b0;
      for (int i = 0; i < 3; i++) send_pkt(mk_pkt(2'b10, 12'(i + 9), 12'(i + 3), 4'd2));
      chk("flush_pre_level", 32'(fifo_level), 32'd3);
      send_byte(8'hE0);
      chk("flush_level", 32'(fifo_level), 32'd0);
      obs.delete();
      ready = 1'b1;
      idle(6);
      chk("flush_no_issue", obs.size(), 32'd0);

      // Randomised stream against a packet-level reference model
      send_byte(8'hE0);
      obs.delete();
      exp_q.delete();
      pkt_q.delete();
      for (int i = 0; i < 400; i++) begin
         logic [7:0] b;
         logic [1:0] op;
         logic       done;
         int         r;
         done = 1'b0;
         r = $urandom_range(0, 99);
         if (r < 25) begin
            op = (r < 3) ? 2'b11 : 2'($urandom_range(0, 2));
            b  = {1'b1, op, 5'($urandom)};
         end else begin
            b = {1'b0, 7'($urandom)};
         end
         send_byte(b);
         if (b[7]) begin
            pkt_q.delete();
            if (b[6:5] != 2'b11) pkt_q.push_back(b);
         end else if (pkt_q.size() != 0) begin
            pkt_q.push_back(b);
            if (pkt_q.size() == 5) begin
               if (pkt_q[0][6:5] == 2'b01 || pkt_q[0][6:5] == 2'b10)
                  exp_q.push_back({pkt_q[0][6:5] == 2'b10,
                                   pkt_q[1][5:0], pkt_q[2][5:0],
                                   pkt_q[3][5:0], pkt_q[4][5:0], pkt_q[0][3:0]});
               pkt_q.delete();
               done = 1'b1;
            end
         end
         idle((done ? 1 : 0) + $urandom_range(0, 2));
      end
      idle(8);
      chk("rand_count", obs.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
         chk("rand_cmd", 32'(obs[i]), 32'(exp_q[i]));
      chk("rand_level", 32'(fifo_level), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
